// File: rtl/aurora_64b66b_rst_pkg.sv
// Shared types for the Aurora 64b66b primary-side reset sequencer:
// sequencer states and the Moore output decode.
package aurora_64b66b_rst_pkg;

  typedef enum logic [2:0] {
    PB_LEAD,
    PMA_HOLD,
    PB_TRAIL,
    WAIT_LINK,
    UP
  } state_e;

  typedef struct packed {
    logic reset_pb;
    logic pma_init;
    logic link_up;
    logic busy;
  } seq_out_t;

  localparam seq_out_t OUT_PB_ONLY = '{reset_pb: 1'b1, pma_init: 1'b0, link_up: 1'b0, busy: 1'b1};
  localparam seq_out_t OUT_PB_PMA  = '{reset_pb: 1'b1, pma_init: 1'b1, link_up: 1'b0, busy: 1'b1};
  localparam seq_out_t OUT_WAIT    = '{reset_pb: 1'b0, pma_init: 1'b0, link_up: 1'b0, busy: 1'b0};
  localparam seq_out_t OUT_UP      = '{reset_pb: 1'b0, pma_init: 1'b0, link_up: 1'b1, busy: 1'b0};

  function automatic seq_out_t decode_state(input state_e s);
    seq_out_t o;
    case (s)
      PB_LEAD:   o = OUT_PB_ONLY;
      PMA_HOLD:  o = OUT_PB_PMA;
      PB_TRAIL:  o = OUT_PB_ONLY;
      WAIT_LINK: o = OUT_WAIT;
      UP:        o = OUT_UP;
      default:   o = OUT_PB_ONLY;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/aurora_64b66b_reset_seq_timer.sv
// Clear-and-count phase timer; tc_o flags that the count has reached the
// terminal value presented for the current phase.
module aurora_64b66b_reset_seq_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == tc_val_i);

endmodule

// File: rtl/aurora_64b66b_reset_seq.sv
// Aurora 64b66b primary-side reset sequencer: orders reset_pb / pma_init,
// waits for channel_up and retries on link timeout or link loss.
module aurora_64b66b_reset_seq
  import aurora_64b66b_rst_pkg::*;
#(
  parameter int unsigned PB_LEAD_CYCLES      = 128,
  parameter int unsigned PMA_HOLD_CYCLES     = 1024,
  parameter int unsigned PB_TRAIL_CYCLES     = 128,
  parameter int unsigned LINK_TIMEOUT_CYCLES = 1048576,
  parameter int unsigned DROP_FILTER         = 16,
  parameter int unsigned CNT_W               = 24,
  parameter int unsigned RETRY_W             = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               reset_req,
  input  logic               channel_up_sync,
  output logic               reset_pb,
  output logic               pma_init,
  output logic               link_up,
  output logic               busy,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int unsigned DROP_W = $clog2(DROP_FILTER + 1);

  state_e             state_q, state_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]   tc_val;
  logic               timer_tc;
  logic               timer_clr;
  logic               timer_en;
  logic               retry_inc;
  seq_out_t           out_s;

  // Terminal count for the phase currently being timed.
  always_comb begin
    tc_val = '0;
    case (state_q)
      PB_LEAD:   tc_val = CNT_W'(PB_LEAD_CYCLES - 1);
      PMA_HOLD:  tc_val = CNT_W'(PMA_HOLD_CYCLES - 1);
      PB_TRAIL:  tc_val = CNT_W'(PB_TRAIL_CYCLES - 1);
      WAIT_LINK: tc_val = CNT_W'(LINK_TIMEOUT_CYCLES - 1);
      default:   tc_val = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    if (reset_req) begin
      state_d = PB_LEAD;
    end else begin
      case (state_q)
        PB_LEAD:  if (timer_tc) state_d = PMA_HOLD;
        PMA_HOLD: if (timer_tc) state_d = PB_TRAIL;
        PB_TRAIL: if (timer_tc) state_d = WAIT_LINK;
        WAIT_LINK: begin
          // A link that comes up on the timeout cycle wins over the retry.
          if (channel_up_sync) begin
            state_d = UP;
          end else if (timer_tc) begin
            state_d   = PB_LEAD;
            retry_inc = 1'b1;
          end
        end
        UP: begin
          if (!channel_up_sync && (drop_q == DROP_W'(DROP_FILTER - 1))) begin
            state_d   = PB_LEAD;
            retry_inc = 1'b1;
          end
        end
        default: state_d = PB_LEAD;
      endcase
    end
  end

  always_comb begin
    drop_d = '0;
    if (state_q == UP && state_d == UP && !channel_up_sync) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_comb begin
    retry_d = retry_q;
    if (retry_inc && (retry_q != {RETRY_W{1'b1}})) begin
      retry_d = retry_q + 1'b1;
    end
  end

  // reset_req re-entering PB_LEAD from PB_LEAD must still restart the timer.
  assign timer_clr = reset_req || (state_d != state_q);
  assign timer_en  = (state_q != UP);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= PB_LEAD;
      retry_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      drop_q  <= drop_d;
    end
  end

  aurora_64b66b_reset_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i    (CLK),
    .rst_n_i  (RST_N),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .tc_val_i (tc_val),
    .tc_o     (timer_tc)
  );

  always_comb begin
    out_s = decode_state(state_q);
  end

  assign reset_pb    = out_s.reset_pb;
  assign pma_init    = out_s.pma_init;
  assign link_up     = out_s.link_up;
  assign busy        = out_s.busy;
  assign retry_count = retry_q;

endmodule

// File: doc/aurora_64b66b_reset_seq.md
Name: aurora_64b66b_reset_seq

Overview:
- Primary-side reset sequencer for the Aurora 64b66b core, clocked in the init-clock domain.
- Generates the required reset_pb / pma_init ordering and hold times after power-up or a software request.
- Watches channel_up, brought in through an external 3-stage reset/level synchronizer, and re-runs the sequence on link timeout or link loss.
- Counts retries for status/debug.

Parameters:
- PB_LEAD_CYCLES, 128: cycles reset_pb is high before pma_init rises (>=1)
- PMA_HOLD_CYCLES, 1024: cycles pma_init is held high (>=1)
- PB_TRAIL_CYCLES, 128: cycles reset_pb stays high after pma_init falls (>=1)
- LINK_TIMEOUT_CYCLES, 1048576: cycles to wait for channel_up before retry (>=1)
- DROP_FILTER, 16: consecutive low cycles of channel_up_sync in UP that count as link loss (>=1)
- CNT_W, 24: timer width; must hold the largest of the cycle parameters
- RETRY_W, 8: retry counter width

Ports:
- CLK  in  1  init clock
- RST_N  in  1  synchronous reset, active-low
- reset_req  in  1  single-cycle software reset request
- channel_up_sync  in  1  channel_up already synchronized into CLK domain
- reset_pb  out  1  Aurora reset_pb
- pma_init  out  1  Aurora pma_init
- link_up  out  1  high while in UP
- busy  out  1  high in PB_LEAD, PMA_HOLD, PB_TRAIL
- retry_count  out  RETRY_W  saturating count of timeout/loss retries

Behaviour:
- Reset values (RST_N low at a rising edge): state=PB_LEAD, timer=0, drop counter=0, retry_count=0.
- Outputs during and after reset: reset_pb=1, pma_init=0, link_up=0, busy=1.
- Outputs are decoded from the registered state only (Moore). They change on the same edge as the state.
- PB_LEAD: reset_pb=1, pma_init=0. Lasts exactly PB_LEAD_CYCLES cycles, then goes to PMA_HOLD.
- PMA_HOLD: reset_pb=1, pma_init=1. Lasts exactly PMA_HOLD_CYCLES cycles, then goes to PB_TRAIL.
- PB_TRAIL: reset_pb=1, pma_init=0. Lasts exactly PB_TRAIL_CYCLES cycles, then goes to WAIT_LINK.
- WAIT_LINK: both outputs 0.
  - channel_up_sync=1 -> UP on the next edge.
  - Otherwise, after LINK_TIMEOUT_CYCLES cycles -> PB_LEAD and retry_count+1.
- UP: link_up=1. The drop counter counts consecutive cycles with channel_up_sync=0 and clears on any 1.
  - On reaching DROP_FILTER -> PB_LEAD and retry_count+1.
- Timer: cleared on every state entry; counts 0..N-1; the transition fires when it reaches N-1.
- channel_up_sync is ignored in PB_LEAD, PMA_HOLD and PB_TRAIL.
- retry_count saturates at 2^RETRY_W-1 and never wraps. Only RST_N clears it.
- reset_req=1 in any state -> PB_LEAD on the next edge, timer cleared, retry_count unchanged.
- Priority, highest first: RST_N; reset_req; channel_up_sync rising in WAIT_LINK; timeout/drop.
  - channel_up_sync=1 on the timeout cycle -> UP, no retry.
  - reset_req on the timeout cycle -> PB_LEAD, no increment.
- RST_N low mid-sequence -> immediate reset values on that edge; the sequence restarts from PB_LEAD.

Decomposition:
- Shared package aurora_64b66b_rst_pkg holds:
  - state enum: PB_LEAD, PMA_HOLD, PB_TRAIL, WAIT_LINK, UP
  - the output-decode constants
- One natural sub-module: aurora_64b66b_reset_seq_timer, a CNT_W clear-and-count timer with a terminal-count compare input.
- The channel_up synchronizer is instantiated outside this block.

Test Plan:
All cases use PB_LEAD=4, PMA_HOLD=8, PB_TRAIL=4, TIMEOUT=32, DROP_FILTER=3, RETRY_W=2. Cycle 0 is the first edge with RST_N high.
- Power-up with channel_up_sync=0:
  - reset_pb=1 in cycles 0-15; pma_init=1 in cycles 4-11; busy falls at 16.
  - At cycle 48: reset_pb=1 and retry_count=1.
- channel_up_sync=1 from cycle 20 -> link_up=1 at cycle 21; retry_count stays 0.
- In UP, channel_up_sync low for 2 cycles -> link_up stays 1. Low for 3 cycles -> PB_LEAD, reset_pb=1, retry_count+1.
- reset_req pulse at cycle 7 (PMA_HOLD):
  - pma_init=0 at cycle 8, then high again at cycles 12-19.
  - retry_count unchanged.
- Continuous timeouts -> retry_count goes 1, 2, 3 and stays 3. RST_N pulse -> retry_count=0, reset_pb=1, pma_init=0.
- channel_up_sync rises exactly on the timeout cycle (cycle 47) -> UP, link_up=1, no increment.
